dircc_status_updater: RTL and testbench

DIRCC_STATUS_UPDATER -- requirements
Module: dircc_status_updater

---
 rtl/dircc_status_updater.sv | 147 ++++++++++++++
 tb/tb_dircc_status_updater.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dircc_status_updater.sv
// Sequences DiRCC status-word updates (OR, exclusive, user write) and snapshots
// over a simple registered-address memory bus with one-cycle read latency.
module dircc_status_updater #(
    parameter int MEM_WIDTH     = 16,
    parameter int ADDRESS_WIDTH = 15,
    parameter int BASE_ADDR     = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [15:0]              req_state,
    input  logic [15:0]              req_extra,
    input  logic [63:0]              req_user,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_write,
    output logic [MEM_WIDTH-1:0]     mem_writedata,
    input  logic [MEM_WIDTH-1:0]     mem_readdata,
    output logic                     snap_valid,
    output logic [15:0]              snap_state,
    output logic [15:0]              snap_extra,
    output logic [63:0]              snap_user
);

    typedef enum logic [2:0] {
        IDLE, RD_STATE, RD_WAIT, WR_STATE, WR_EXTRA, WR_USER, SNAP
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] BASE = ADDRESS_WIDTH'(BASE_ADDR);

    function automatic logic [ADDRESS_WIDTH-1:0] word_addr(input logic [3:0] off);
        return BASE + ADDRESS_WIDTH'(off);
    endfunction

    state_t            state_reg;
    logic [15:0]       dstate_reg;
    logic [15:0]       extra_reg;
    logic [63:0]       user_reg;
    logic [2:0]        cnt_reg;
    logic [4:0][15:0]  snap_buf_reg;

    logic [2:0]  cnt_next;
    logic [15:0] rd_word;

    assign cnt_next  = cnt_reg + 3'd1;
    assign rd_word   = 16'(mem_readdata);
    assign req_ready = (state_reg == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            dstate_reg    <= '0;
            extra_reg     <= '0;
            user_reg      <= '0;
            cnt_reg       <= '0;
            snap_buf_reg  <= '0;
            mem_address   <= BASE;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
            snap_valid    <= 1'b0;
            snap_state    <= '0;
            snap_extra    <= '0;
            snap_user     <= '0;
        end else begin
            snap_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    mem_address   <= BASE;
                    mem_write     <= 1'b0;
                    mem_writedata <= '0;
                    if (req_valid) begin
                        dstate_reg <= req_state;
                        extra_reg  <= req_extra;
                        user_reg   <= req_user;
                        cnt_reg    <= '0;
                        // Bus outputs for the first step are loaded here so activity starts next cycle.
                        case (req_op)
                            2'b00: state_reg <= RD_STATE;
                            2'b01: begin
                                state_reg     <= WR_STATE;
                                mem_write     <= 1'b1;
                                mem_writedata <= MEM_WIDTH'(req_state);
                            end
                            2'b10: begin
                                state_reg     <= WR_USER;
                                mem_address   <= word_addr(4'd4);
                                mem_write     <= 1'b1;
                                mem_writedata <= MEM_WIDTH'(req_user[15:0]);
                            end
                            default: state_reg <= SNAP;
                        endcase
                    end
                end
                RD_STATE: state_reg <= RD_WAIT;
                RD_WAIT: begin
                    state_reg     <= WR_STATE;
                    mem_write     <= 1'b1;
                    mem_writedata <= MEM_WIDTH'(rd_word | dstate_reg);
                end
                WR_STATE: begin
                    state_reg     <= WR_EXTRA;
                    mem_address   <= word_addr(4'd2);
                    mem_write     <= 1'b1;
                    mem_writedata <= MEM_WIDTH'(extra_reg);
                end
                WR_EXTRA: begin
                    state_reg     <= IDLE;
                    mem_address   <= BASE;
                    mem_write     <= 1'b0;
                    mem_writedata <= '0;
                end
                WR_USER: begin
                    if (cnt_reg == 3'd3) begin
                        state_reg     <= IDLE;
                        mem_address   <= BASE;
                        mem_write     <= 1'b0;
                        mem_writedata <= '0;
                    end else begin
                        cnt_reg       <= cnt_next;
                        mem_address   <= word_addr({cnt_next, 1'b0} + 4'd4);
                        mem_writedata <= MEM_WIDTH'(user_reg[{cnt_next[1:0], 4'b0000} +: 16]);
                    end
                end
                SNAP: begin
                    cnt_reg <= cnt_next;
                    if (cnt_reg < 3'd5)
                        mem_address <= word_addr({cnt_next, 1'b0});
                    else
                        mem_address <= BASE;
                    // Read data trails the address by one cycle, hence the index offset.
                    if (cnt_reg != 3'd0 && cnt_reg != 3'd6)
                        snap_buf_reg[cnt_reg - 3'd1] <= rd_word;
                    if (cnt_reg == 3'd6) begin
                        state_reg  <= IDLE;
                        snap_valid <= 1'b1;
                        snap_state <= snap_buf_reg[0];
                        snap_extra <= snap_buf_reg[1];
                        snap_user  <= {rd_word, snap_buf_reg[4], snap_buf_reg[3], snap_buf_reg[2]};
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dircc_status_updater.sv
// Directed bench for dircc_status_updater with a one-cycle-latency status memory model.
module tb_dircc_status_updater;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_state;
    logic [15:0] req_extra;
    logic [63:0] req_user;
    logic [14:0] mem_address;
    logic        mem_write;
    logic [15:0] mem_writedata;
    logic [15:0] mem_readdata;
    logic        snap_valid;
    logic [15:0] snap_state;
    logic [15:0] snap_extra;
    logic [63:0] snap_user;

    logic [15:0] mem [0:15];
    logic        pre_we;
    logic [3:0]  pre_idx;
    logic [15:0] pre_val;
    int          wr_count;
    int          wc;
    int          tests;
    int          failed;

    dircc_status_updater dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_state     (req_state),
        .req_extra     (req_extra),
        .req_user      (req_user),
        .mem_address   (mem_address),
        .mem_write     (mem_write),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .snap_valid    (snap_valid),
        .snap_state    (snap_state),
        .snap_extra    (snap_extra),
        .snap_user     (snap_user)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        wr_count     = 0;
        mem_readdata = 16'h0000;
    end

    always @(posedge clk) begin
        mem_readdata <= mem[mem_address[4:1]];
        if (pre_we)
            mem[pre_idx] <= pre_val;
        else if (mem_write) begin
            mem[mem_address[4:1]] <= mem_writedata;
            wr_count <= wr_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic rdy, input logic [14:0] addr,
                           input logic wr, input logic [15:0] data);
        chk({tag, "_ready"}, 64'(req_ready), 64'(rdy));
        chk({tag, "_addr"},  64'(mem_address), 64'(addr));
        chk({tag, "_write"}, 64'(mem_write), 64'(wr));
        chk({tag, "_data"},  64'(mem_writedata), 64'(data));
    endtask

    initial begin
        tests = 0; failed = 0;
        reset_n = 1'b1; req_valid = 1'b0; req_op = 2'b00;
        req_state = '0; req_extra = '0; req_user = '0;
        pre_we = 1'b0; pre_idx = '0; pre_val = '0;
        #1 reset_n = 1'b0;

        // Reset values, with status word preloaded to 0x0005
        pre_we = 1'b1; pre_idx = 4'd0; pre_val = 16'h0005;
        tick();
        pre_we = 1'b0;
        chk_bus("reset", 1'b1, 15'd0, 1'b0, 16'h0000);
        chk("reset_snap_valid", 64'(snap_valid), 64'd0);
        chk("reset_snap_state", 64'(snap_state), 64'd0);
        chk("reset_snap_user", snap_user, 64'd0);

        // op 00 presented before reset release: accepted on first edge
        req_valid = 1'b1; req_op = 2'b00; req_state = 16'h0030; req_extra = 16'h1234;
        #2 reset_n = 1'b1;
        tick();
        req_valid = 1'b0; req_state = 16'hFFFF; req_extra = 16'hFFFF;
        chk_bus("op00_rd", 1'b0, 15'd0, 1'b0, 16'h0000);
        tick(); chk_bus("op00_wait", 1'b0, 15'd0, 1'b0, 16'h0000);
        tick(); chk_bus("op00_wrs", 1'b0, 15'd0, 1'b1, 16'h0035);
        tick(); chk_bus("op00_wre", 1'b0, 15'd2, 1'b1, 16'h1234);
        tick(); chk_bus("op00_done", 1'b1, 15'd0, 1'b0, 16'h0000);
        chk("op00_mem0", 64'(mem[0]), 64'h0035);
        chk("op00_mem1", 64'(mem[1]), 64'h1234);

        // op 10 user write, issued in the idle cycle right after completion
        req_valid = 1'b1; req_op = 2'b10; req_user = 64'h1122334455667788;
        tick();
        req_valid = 1'b0; req_user = '0;
        chk_bus("usr_w0", 1'b0, 15'd4, 1'b1, 16'h7788);
        tick(); chk_bus("usr_w1", 1'b0, 15'd6, 1'b1, 16'h5566);
        tick(); chk_bus("usr_w2", 1'b0, 15'd8, 1'b1, 16'h3344);
        tick(); chk_bus("usr_w3", 1'b0, 15'd10, 1'b1, 16'h1122);
        tick(); chk_bus("usr_done", 1'b1, 15'd0, 1'b0, 16'h0000);

        // op 11 snapshot
        wc = wr_count;
        req_valid = 1'b1; req_op = 2'b11;
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk_bus("snap_addr", 1'b0, 15'(2 * k), 1'b0, 16'h0000);
            chk("snap_valid_early", 64'(snap_valid), 64'd0);
            tick();
        end
        chk_bus("snap_c7", 1'b0, 15'd0, 1'b0, 16'h0000);
        chk("snap_valid_c7", 64'(snap_valid), 64'd0);
        tick();
        chk("snap_valid_pulse", 64'(snap_valid), 64'd1);
        chk("snap_state", 64'(snap_state), 64'h0035);
        chk("snap_extra", 64'(snap_extra), 64'h1234);
        chk("snap_user", snap_user, 64'h1122334455667788);
        chk("snap_ready", 64'(req_ready), 64'd1);
        tick();
        chk("snap_valid_end", 64'(snap_valid), 64'd0);
        chk("snap_state_hold", 64'(snap_state), 64'h0035);
        chk("snap_no_writes", 64'(wr_count - wc), 64'd0);

        // op 01 exclusive, then op 00 back-to-back with req_valid held
        pre_we = 1'b1; pre_idx = 4'd0; pre_val = 16'h00FF;
        tick();
        pre_we = 1'b0;
        wc = wr_count;
        req_valid = 1'b1; req_op = 2'b01; req_state = 16'h0002; req_extra = 16'h0000;
        tick();
        chk_bus("x_wrs", 1'b0, 15'd0, 1'b1, 16'h0002);
        req_op = 2'b00; req_state = 16'h0100; req_extra = 16'h0BEE;
        tick(); chk_bus("x_wre", 1'b0, 15'd2, 1'b1, 16'h0000);
        tick(); chk_bus("b2b_idle", 1'b1, 15'd0, 1'b0, 16'h0000);
        chk("x_write_count", 64'(wr_count - wc), 64'd2);
        chk("x_mem0", 64'(mem[0]), 64'h0002);
        tick();
        req_valid = 1'b0;
        chk_bus("b2b_rd", 1'b0, 15'd0, 1'b0, 16'h0000);
        tick(); chk_bus("b2b_wait", 1'b0, 15'd0, 1'b0, 16'h0000);
        tick(); chk_bus("b2b_wrs", 1'b0, 15'd0, 1'b1, 16'h0102);
        tick(); chk_bus("b2b_wre", 1'b0, 15'd2, 1'b1, 16'h0BEE);
        tick(); chk_bus("b2b_done", 1'b1, 15'd0, 1'b0, 16'h0000);

        // Reset during third user word: aborted, no further writes
        req_valid = 1'b1; req_op = 2'b10; req_user = 64'hAAAABBBBCCCCDDDD;
        tick();
        req_valid = 1'b0;
        chk_bus("rst_w0", 1'b0, 15'd4, 1'b1, 16'hDDDD);
        tick(); chk_bus("rst_w1", 1'b0, 15'd6, 1'b1, 16'hCCCC);
        tick(); chk_bus("rst_w2", 1'b0, 15'd8, 1'b1, 16'hBBBB);
        wc = wr_count;
        reset_n = 1'b0;
        #1;
        chk_bus("rst_now", 1'b1, 15'd0, 1'b0, 16'h0000);
        chk("rst_snap_valid", 64'(snap_valid), 64'd0);
        chk("rst_snap_state", 64'(snap_state), 64'd0);
        chk("rst_snap_extra", 64'(snap_extra), 64'd0);
        chk("rst_snap_user", snap_user, 64'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("rst_no_writes", 64'(wr_count - wc), 64'd0);
        chk("rst_mem_w0", 64'(mem[2]), 64'hDDDD);
        chk("rst_mem_w2", 64'(mem[4]), 64'h3344);
        chk("rst_mem_w3", 64'(mem[5]), 64'h1122);
        chk_bus("rst_idle", 1'b1, 15'd0, 1'b0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
